mem_arbiter: RTL



---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Request-unit and RAM-port signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface mem_arbiter_if;
   // Request unit side
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        ihit;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dhit;
   // Shared RAM side
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests beat instruction requests, one access at a time.
// Optional request timeout abort is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] ERR_WORD = 32'hBAD0_BAD0
) (
   input  logic              CLK,
   input  logic              nRST,
   mem_arbiter_if.slave      bus,
   output logic [1:0]        state_dbg
);

   // Handshake: a request enable is sampled only in IDLE; the requester keeps it
   // high until it sees its one-cycle hit pulse, then drops it.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DREQ = 2'd1,
      IREQ = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [1:0]  RAM_ACCESS  = 2'd2;
   localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);

   state_t      state;
   state_t      next_state;

   logic [31:0] addr_q;
   logic [31:0] store_q;
   logic        wr_q;
   logic        data_q;
   logic [31:0] iload_q;
   logic [31:0] dload_q;

   logic        grant_data;
   logic        grant_instr;
   logic        done_access;

`ifdef MEM_ARB_TIMEOUT_EN
   logic [31:0] cnt;
   logic        abort_q;
   logic        done_abort;
`else
   logic        unused_cfg;
   assign unused_cfg = ^{TIMEOUT_CNT, ERR_WORD};
`endif

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and grant/complete decisions
   always_comb begin
      next_state  = state;
      grant_data  = 1'b0;
      grant_instr = 1'b0;
      done_access = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      done_abort  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (bus.dREN || bus.dWEN) begin
               grant_data = 1'b1;
               next_state = DREQ;
            end else if (bus.iREN) begin
               grant_instr = 1'b1;
               next_state  = IREQ;
            end
         end
         DREQ, IREQ: begin
            if (bus.ramstate == RAM_ACCESS) begin
               done_access = 1'b1;
               next_state  = RESP;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cnt == TIMEOUT_CNT) begin
               done_abort = 1'b1;
               next_state = RESP;
            end
`endif
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Latched request copies that drive the RAM port for the whole access
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         addr_q  <= 32'd0;
         store_q <= 32'd0;
         wr_q    <= 1'b0;
         data_q  <= 1'b0;
      end else if (grant_data) begin
         addr_q  <= bus.daddr;
         store_q <= bus.dstore;
         wr_q    <= bus.dWEN;
         data_q  <= 1'b1;
      end else if (grant_instr) begin
         addr_q  <= bus.iaddr;
         wr_q    <= 1'b0;
         data_q  <= 1'b0;
      end
   end

   // Returned read data; each side holds until its own next completion
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         iload_q <= 32'd0;
         dload_q <= 32'd0;
      end else if (done_access) begin
         if (data_q && !wr_q) begin
            dload_q <= bus.ramload;
         end else if (!data_q) begin
            iload_q <= bus.ramload;
         end
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (done_abort) begin
         if (data_q) begin
            dload_q <= ERR_WORD;
         end else begin
            iload_q <= ERR_WORD;
         end
      end
`endif
   end

`ifdef MEM_ARB_TIMEOUT_EN
   // Wait counter: cleared on grant, counts every waiting cycle without ACCESS
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt     <= 32'd0;
         abort_q <= 1'b0;
      end else begin
         if (grant_data || grant_instr) begin
            cnt     <= 32'd0;
            abort_q <= 1'b0;
         end else begin
            if ((state == DREQ || state == IREQ) && !done_access) begin
               cnt <= cnt + 32'd1;
            end
            if (done_abort) begin
               abort_q <= 1'b1;
            end
         end
      end
   end

   assign bus.err = (state == RESP) && abort_q;
`else
   assign bus.err = 1'b0;
`endif

   // RAM enables and hit pulses decode straight from state so reset kills them at once
   always_comb begin
      bus.ramREN = 1'b0;
      bus.ramWEN = 1'b0;
      bus.ihit   = 1'b0;
      bus.dhit   = 1'b0;
      case (state)
         DREQ: begin
            bus.ramREN = !wr_q;
            bus.ramWEN = wr_q;
         end
         IREQ: begin
            bus.ramREN = 1'b1;
         end
         RESP: begin
            bus.dhit = data_q;
            bus.ihit = !data_q;
         end
         default: begin
         end
      endcase
   end

   assign bus.ramaddr  = addr_q;
   assign bus.ramstore = store_q;
   assign bus.iload    = iload_q;
   assign bus.dload    = dload_q;
   assign state_dbg    = state;

endmodule
